// File: rtl/tqvp_intercal_readout.sv
// INTERCAL READ OUT formatter: turns a 16-bit value into butchered-Roman bytes,
// thousands first with bit7 set as the overbar, drained one byte per read of 0x04.
module tqvp_intercal_readout (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready
);

    // state  | meaning
    // S_IDLE | no conversion running
    // S_DIV  | repeated subtraction of 1000: R = remainder, T = thousands
    // S_HI   | emitting Roman digits of T with overbar
    // S_LO   | emitting Roman digits of R ('_' when the whole value is 0)
    // S_FIN  | conversion finished, raise done and drop busy
    typedef enum logic [2:0] {S_IDLE, S_DIV, S_HI, S_LO, S_FIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] r_q, r_d;
    logic [6:0]  t_q, t_d;
    logic [9:0]  v_q, v_d;
    logic [3:0]  k_q, k_d;
    logic        sub_q, sub_d;
    logic [7:0]  char_q, char_d;
    logic        char_valid_q, char_valid_d;
    logic [7:0]  count_q, count_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        wr_en;
    logic        rd_char;
    logic [9:0]  w_k;
    logic [6:0]  ch;
    logic        unused_ok;

    function automatic logic [9:0] weight(input logic [3:0] k);
        case (k)
            4'd0:    weight = 10'd1000;
            4'd1:    weight = 10'd900;
            4'd2:    weight = 10'd500;
            4'd3:    weight = 10'd400;
            4'd4:    weight = 10'd100;
            4'd5:    weight = 10'd90;
            4'd6:    weight = 10'd50;
            4'd7:    weight = 10'd40;
            4'd8:    weight = 10'd10;
            4'd9:    weight = 10'd9;
            4'd10:   weight = 10'd5;
            4'd11:   weight = 10'd4;
            default: weight = 10'd1;
        endcase
    endfunction

    // First character of each table string
    function automatic logic [6:0] char_first(input logic [3:0] k);
        case (k)
            4'd0:                      char_first = 7'h4D;
            4'd1, 4'd3, 4'd4:          char_first = 7'h43;
            4'd2:                      char_first = 7'h44;
            4'd5, 4'd7, 4'd8:          char_first = 7'h58;
            4'd6:                      char_first = 7'h4C;
            4'd10:                     char_first = 7'h56;
            default:                   char_first = 7'h49;
        endcase
    endfunction

    // Second character, only meaningful for the odd (subtractive) entries
    function automatic logic [6:0] char_second(input logic [3:0] k);
        case (k)
            4'd1:    char_second = 7'h4D;
            4'd3:    char_second = 7'h44;
            4'd5:    char_second = 7'h43;
            4'd7:    char_second = 7'h4C;
            4'd9:    char_second = 7'h58;
            default: char_second = 7'h56;
        endcase
    endfunction

    assign uo_out     = 8'h00;
    assign data_ready = (data_read_n != 2'b11);
    assign unused_ok  = ^{ui_in, data_in[31:16]};

    assign wr_en   = (address == 6'h00) && ((data_write_n == 2'b01) || (data_write_n == 2'b10));
    assign rd_char = (address == 6'h04) && (data_read_n != 2'b11);
    assign w_k     = weight(k_q);
    assign ch      = sub_q ? char_second(k_q) : char_first(k_q);

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        t_d          = t_q;
        v_d          = v_q;
        k_d          = k_q;
        sub_d        = sub_q;
        char_d       = char_q;
        char_valid_d = char_valid_q;
        count_d      = count_q;
        done_d       = done_q;
        busy_d       = busy_q;

        if (rd_char && char_valid_q)
            char_valid_d = 1'b0;

        case (state_q)
            S_DIV: begin
                if (r_q >= 16'd1000) begin
                    r_d = r_q - 16'd1000;
                    t_d = t_q + 7'd1;
                end else begin
                    k_d   = 4'd0;
                    sub_d = 1'b0;
                    if (t_q == 7'd0) begin
                        state_d = S_LO;
                        v_d     = r_q[9:0];
                    end else begin
                        state_d = S_HI;
                        v_d     = {3'b000, t_q};
                    end
                end
            end
            S_HI, S_LO: begin
                if (k_q == 4'd13) begin
                    if (state_q == S_HI) begin
                        state_d = S_LO;
                        v_d     = r_q[9:0];
                        k_d     = 4'd0;
                    end else if (count_q != 8'd0) begin
                        state_d = S_FIN;
                    end else if (!char_valid_q) begin
                        // nothing was emitted, so the value was zero
                        char_d       = 8'h5F;
                        char_valid_d = 1'b1;
                        count_d      = 8'd1;
                        state_d      = S_FIN;
                    end
                end else if (v_q < w_k) begin
                    k_d = k_q + 4'd1;
                end else if (!char_valid_q) begin
                    char_d       = {(state_q == S_HI), ch};
                    char_valid_d = 1'b1;
                    if (count_q != 8'hFF)
                        count_d = count_q + 8'd1;
                    if (k_q[0] && !sub_q) begin
                        sub_d = 1'b1;
                    end else begin
                        sub_d = 1'b0;
                        v_d   = v_q - w_k;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // a new value always wins, including over a pop in the same cycle
        if (wr_en) begin
            state_d      = S_DIV;
            r_d          = data_in[15:0];
            t_d          = 7'd0;
            v_d          = 10'd0;
            k_d          = 4'd0;
            sub_d        = 1'b0;
            char_d       = 8'h00;
            char_valid_d = 1'b0;
            count_d      = 8'd0;
            done_d       = 1'b0;
            busy_d       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            r_q          <= 16'd0;
            t_q          <= 7'd0;
            v_q          <= 10'd0;
            k_q          <= 4'd0;
            sub_q        <= 1'b0;
            char_q       <= 8'h00;
            char_valid_q <= 1'b0;
            count_q      <= 8'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            t_q          <= t_d;
            v_q          <= v_d;
            k_q          <= k_d;
            sub_q        <= sub_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
            count_q      <= count_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        data_out = 32'h0;
        if (data_read_n != 2'b11) begin
            case (address)
                6'h00:   data_out = {16'h0, count_q, 5'b0, done_q, char_valid_q, busy_q};
                6'h04:   data_out = {24'h0, (char_valid_q ? char_q : 8'h00)};
                default: data_out = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_intercal_readout.sv
// Bench for tqvp_intercal_readout: directed test-plan cases with literal
// expectations plus randomized values checked against a greedy Roman model.
module tb_tqvp_intercal_readout;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int         W  [13] = '{1000, 900, 500, 400, 100, 90, 50, 40, 10, 9, 5, 4, 1};
    logic [7:0] C0 [13] = '{8'h4D, 8'h43, 8'h44, 8'h43, 8'h43, 8'h58, 8'h4C, 8'h58, 8'h58, 8'h49, 8'h56, 8'h49, 8'h49};
    logic [7:0] C1 [13] = '{8'h00, 8'h4D, 8'h00, 8'h44, 8'h00, 8'h43, 8'h00, 8'h4C, 8'h00, 8'h58, 8'h00, 8'h56, 8'h00};

    tqvp_intercal_readout dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ui_in        (ui_in),
        .uo_out       (uo_out),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_roman(input int v, input logic [7:0] flag);
        for (int k = 0; k < 13; k++) begin
            while (v >= W[k]) begin
                exp_q.push_back(C0[k] | flag);
                if (C1[k] != 8'h00) exp_q.push_back(C1[k] | flag);
                v -= W[k];
            end
        end
    endtask

    task automatic build_model(input int value);
        exp_q.delete();
        if (value == 0) exp_q.push_back(8'h5F);
        else begin
            push_roman(value / 1000, 8'h80);
            push_roman(value % 1000, 8'h00);
        end
    endtask

    // Compare process: every cycle, observe the bus and the character stream.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            check("uo_out", {24'h0, uo_out}, 32'h0);
            check("data_ready", {31'h0, data_ready}, {31'h0, data_read_n != 2'b11});
            if (data_read_n == 2'b11)
                check("idle_bus", data_out, 32'h0);
            else if (address == 6'h04 && data_out != 32'h0) begin
                if (exp_q.size() == 0)
                    check("unexpected_char", data_out, 32'h0);
                else begin
                    e = exp_q.pop_front();
                    check("char", data_out, {24'h0, e});
                end
            end
        end
    end

    // Each bus task starts at a negedge and ends at the next one.
    task automatic idle();
        @(negedge clk);
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        address     = a;
        data_read_n = 2'b10;
        #2 d = data_out;
        @(negedge clk);
        data_read_n = 2'b11;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        if (a == 6'h00 && (wn == 2'b01 || wn == 2'b10)) build_model(int'(d[15:0]));
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic pop_n(input int n, input int max_gap);
        logic [31:0] s, c;
        int popped = 0;
        int budget = 0;
        while (popped < n) begin
            rd(6'h00, s);
            if (s[1]) begin
                repeat ($urandom_range(0, max_gap)) idle();
                rd(6'h04, c);
                check("pop_nonzero", {31'h0, c != 32'h0}, 32'h1);
                got_q.push_back(c[7:0]);
                popped++;
            end
            budget++;
            if (budget > 3000) begin
                check("pop_timeout", 32'h0, 32'h1);
                break;
            end
        end
    endtask

    task automatic drain(input int max_gap);
        logic [31:0] s, c;
        int budget = 0;
        forever begin
            rd(6'h00, s);
            if (s[1]) begin
                repeat ($urandom_range(0, max_gap)) idle();
                rd(6'h04, c);
                check("pop_nonzero", {31'h0, c != 32'h0}, 32'h1);
                got_q.push_back(c[7:0]);
            end else if (s[2]) break;
            budget++;
            if (budget > 3000) begin
                check("drain_timeout", 32'h0, 32'h1);
                break;
            end
        end
        check("final_busy", {31'h0, s[0]}, 32'h0);
        check("final_count", {24'h0, s[15:8]}, got_q.size());
        check("model_leftover", exp_q.size(), 32'h0);
    endtask

    task automatic cmp_lit(input string name, input int len, input logic [127:0] lit);
        check({name, "_len"}, got_q.size(), len);
        for (int i = 0; i < len && i < got_q.size(); i++)
            check(name, {24'h0, got_q[i]}, {24'h0, lit[8*(len-1-i) +: 8]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1);
    end

    initial begin
        logic [31:0] s, c;
        int v;
        int corner [10] = '{1, 999, 1000, 1001, 3888, 4000, 9999, 10000, 49999, 65000};

        rst_n = 1'b0; ui_in = 8'hA5; address = 6'h00; data_in = 32'h0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data_out", data_out, 32'h0);
        check("rst_data_ready", {31'h0, data_ready}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        rd(6'h00, s); check("rst_status", s, 32'h0);
        rd(6'h04, s); check("rst_char", s, 32'h0);
        rd(6'h08, s); check("rst_other", s, 32'h0);

        got_q.delete(); wr(6'h00, 32'd4, 2'b10); drain(0);
        cmp_lit("v4", 2, 128'h4956);

        got_q.delete(); wr(6'h00, 32'hABCD_07CF, 2'b01); drain(1);
        cmp_lit("v1999", 7, 128'hC9434D58434958);

        got_q.delete(); wr(6'h00, 32'd65535, 2'b10); drain(2);
        cmp_lit("v65535", 8, 128'hCCD8D644585858_56);

        got_q.delete(); wr(6'h00, 32'd0, 2'b10); drain(0);
        cmp_lit("v0", 1, 128'h5F);

        // ignored writes leave the finished "0" status untouched
        wr(6'h00, 32'd7, 2'b00);
        wr(6'h08, 32'd7, 2'b10);
        rd(6'h00, s); check("ignored_write", s, 32'h0000_0104);
        rd(6'h04, s); check("empty_slot", s, 32'h0);

        got_q.delete(); wr(6'h00, 32'd3999, 2'b10);
        repeat (200) idle();
        rd(6'h00, s); check("bp_status", s, 32'h0000_0103);
        drain(0);
        cmp_lit("v3999", 9, 128'hC9C9C9434D58434958);

        got_q.delete(); wr(6'h00, 32'd3999, 2'b10);
        pop_n(2, 0);
        cmp_lit("abort_pre", 2, 128'hC9C9);
        wr(6'h00, 32'd5, 2'b10);
        rd(6'h00, s); check("abort_status", s, 32'h0000_0001);
        got_q.delete(); drain(0);
        cmp_lit("abort_v5", 1, 128'h56);

        wr(6'h00, 32'd38888, 2'b10);
        repeat (30) idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        rd(6'h00, s); check("midrst_status", s, 32'h0);
        rd(6'h04, s); check("midrst_char", s, 32'h0);

        for (int i = 0; i < 30; i++) begin
            v = (i < 10) ? corner[i] : int'($urandom_range(0, 65535));
            got_q.delete();
            wr(6'h00, v, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
            drain(3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
